wallace_dot_accumulator: RTL

//  Sequential stage that wraps the 8x8 WallaceMultiplier and consumes its product.

---
 rtl/wallace_dot_accumulator_pkg.sv | 6 +
 rtl/wallace_dot_accumulator_if.sv | 10 +
 rtl/wallace_dot_accumulator_mult.sv | 24 ++
 rtl/wallace_dot_accumulator.sv | 83 ++++++++
 4 files changed

// File: rtl/wallace_dot_accumulator_pkg.sv
// wallace_dot_accumulator_pkg: shared widths and FSM state encoding for the dot-product accumulator
package wallace_dot_accumulator_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {ACCUM = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/wallace_dot_accumulator_if.sv
// wallace_dot_accumulator_if: operand stream in, frame result out, both valid/ready
interface wallace_dot_accumulator_if #(parameter int ACC_W = 24, parameter int CNT_W = 8);
  import wallace_dot_accumulator_pkg::*;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [OP_W-1:0] in_a, in_b;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  modport master (output in_valid, in_a, in_b, in_last, out_ready, input in_ready, out_valid, out_sum, out_count, out_ovf);
  modport slave (input in_valid, in_a, in_b, in_last, out_ready, output in_ready, out_valid, out_sum, out_count, out_ovf);
endinterface

// File: rtl/wallace_dot_accumulator_mult.sv
// WallaceMultiplier: 8x8 unsigned carry-save tree multiplier, product presented on bits [16:1]
module WallaceMultiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [17:0] product
);
  logic [15:0] pp [8];
  logic [31:0] l0, l1, l2, l3, l4, l5;
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    logic [14:0] c;
    c = (x[14:0] & y[14:0]) | (x[14:0] & z[14:0]) | (y[14:0] & z[14:0]);
    return {c, 1'b0, x ^ y ^ z};
  endfunction
  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = b[i] ? 16'(a) << i : '0;
  end
  assign l0 = csa(pp[0], pp[1], pp[2]);
  assign l1 = csa(pp[3], pp[4], pp[5]);
  assign l2 = csa(l0[15:0], l0[31:16], l1[15:0]);
  assign l3 = csa(l1[31:16], pp[6], pp[7]);
  assign l4 = csa(l2[15:0], l2[31:16], l3[15:0]);
  assign l5 = csa(l4[15:0], l4[31:16], l3[31:16]);
  assign product = {1'b0, l5[15:0] + l5[31:16], 1'b0};
endmodule

// File: rtl/wallace_dot_accumulator.sv
// wallace_dot_accumulator: sums 8x8 products over a frame and emits one dot-product result per frame
module wallace_dot_accumulator
  import wallace_dot_accumulator_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  wallace_dot_accumulator_if.slave bus
);
  state_t state;
  logic [17:0] mp;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum_nx;
  logic [CNT_W-1:0] cnt;
  logic pv, p_last, rdy, vld, ovf, accept, unused_mp;
  assign accept = bus.in_valid && rdy;
  assign sum_nx = {1'b0, acc} + (ACC_W+1)'(prod);
  assign unused_mp = ^{mp[17], mp[0]};
  WallaceMultiplier u_mult (.a(bus.in_a), .b(bus.in_b), .product(mp));
  // product pipeline stage: capture the product of each accepted beat
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pv <= 1'b0;
      p_last <= 1'b0;
      prod <= '0;
    end else begin
      pv <= accept;
      if (accept) begin
        prod <= mp[16:1];
        p_last <= bus.in_last;
      end
    end
  // accumulator, saturating beat count and sticky carry; cleared when the result is taken
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == DONE && bus.out_ready) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (pv) begin
      acc <= sum_nx[ACC_W-1:0];
      ovf <= ovf | sum_nx[ACC_W];
      cnt <= &cnt ? cnt : cnt + CNT_W'(1);
    end
  // frame FSM with registered ready/valid outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ACCUM;
      rdy <= 1'b1;
      vld <= 1'b0;
    end else
      case (state)
        ACCUM: if (accept && bus.in_last) begin
          state <= DRAIN;
          rdy <= 1'b0;
        end
        DRAIN: if (p_last) begin
          state <= DONE;
          vld <= 1'b1;
        end
        DONE: if (bus.out_ready) begin
          state <= ACCUM;
          rdy <= 1'b1;
          vld <= 1'b0;
        end
        default: begin
          state <= ACCUM;
          rdy <= 1'b1;
          vld <= 1'b0;
        end
      endcase
  assign bus.in_ready = rdy;
  assign bus.out_valid = vld;
  assign bus.out_sum = acc;
  assign bus.out_count = cnt;
  assign bus.out_ovf = ovf;
endmodule
